// File: rtl/uart_rx_cfg_if.sv
// Receive-side result bundle of uart_rx_cfg: received word, qualifiers and status.
// The receiver drives the master modport; a byte consumer reads the slave modport.
interface uart_rx_cfg_if #(
    parameter int unsigned DataBits = 8
);
    logic                o_rx_valid;
    logic [DataBits-1:0] o_rx_data;
    logic                o_parity_err;
    logic                o_frame_err;
    logic                o_break;
    logic                o_busy;

    modport master (
        output o_rx_valid,
        output o_rx_data,
        output o_parity_err,
        output o_frame_err,
        output o_break,
        output o_busy
    );

    modport slave (
        input o_rx_valid,
        input o_rx_data,
        input o_parity_err,
        input o_frame_err,
        input o_break,
        input o_busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable width/parity/stop bits, oversampled
// 3-sample majority vote, parity/framing error and line-break reporting.
module uart_rx_cfg #(
    parameter int unsigned ClkFreq    = 27_000_000,
    parameter int unsigned BaudRate   = 115200,
    parameter int unsigned DataBits   = 8,
    parameter int unsigned ParityMode = 0,
    parameter int unsigned StopBits   = 1,
    parameter int unsigned Oversample = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_rx,
    uart_rx_cfg_if.master  o_rx_if
);
    localparam int unsigned Div   = ClkFreq / (BaudRate * Oversample);
    localparam int unsigned DivW  = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned TickW = $clog2(Oversample);
    localparam int unsigned BitW  = $clog2(DataBits + 1);

    localparam logic [DivW-1:0]  DivLast  = DivW'(Div - 1);
    localparam logic [TickW-1:0] SampA    = TickW'(Oversample / 2 - 1);
    localparam logic [TickW-1:0] SampB    = TickW'(Oversample / 2);
    localparam logic [TickW-1:0] SampC    = TickW'(Oversample / 2 + 1);
    localparam logic [TickW-1:0] TickLast = TickW'(Oversample - 1);
    localparam logic [BitW-1:0]  DataLast = BitW'(DataBits - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(StopBits - 1);

    generate
        if (Div < 1) begin : g_chk_div
            $error("uart_rx_cfg: clock too slow for BaudRate * Oversample");
        end
        if (DataBits < 5 || DataBits > 9) begin : g_chk_data
            $error("uart_rx_cfg: DataBits must be 5..9");
        end
        if (ParityMode > 2) begin : g_chk_par
            $error("uart_rx_cfg: ParityMode must be 0, 1 or 2");
        end
        if (StopBits < 1 || StopBits > 2) begin : g_chk_stop
            $error("uart_rx_cfg: StopBits must be 1 or 2");
        end
        if (Oversample < 8 || (Oversample % 2) != 0) begin : g_chk_os
            $error("uart_rx_cfg: Oversample must be even and >= 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                r_sync;
    logic                r_rxs;
    logic                r_rxs_prev;
    logic [DivW-1:0]     r_div_cnt;
    logic [TickW-1:0]    r_tick_cnt;
    logic [2:0]          r_samp;
    logic                r_dec;
    logic [BitW-1:0]     r_bit_cnt;
    logic [DataBits-1:0] r_shift;
    logic                r_par_bit;
    logic                r_par_err;
    logic                r_ferr_acc;

    logic                r_rx_valid;
    logic [DataBits-1:0] r_rx_data;
    logic                r_parity_err;
    logic                r_frame_err;
    logic                r_break;

    logic w_start_edge;
    logic w_tick;
    logic w_bit_end;
    logic w_maj;
    logic w_last_stop;
    logic w_ferr;
    logic w_break;
    logic w_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync     <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync     <= i_rx;
            r_rxs      <= r_sync;
            r_rxs_prev <= r_rxs;
        end
    end

    assign w_start_edge = (r_state == S_IDLE) && r_rxs_prev && !r_rxs;
    assign w_tick       = (r_div_cnt == DivLast);
    assign w_bit_end    = w_tick && (r_tick_cnt == TickLast);
    assign w_maj        = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

    // Start edge re-phases both counters so bit centres line up with this frame.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_edge) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_samp     <= '1;
            r_dec      <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_dec     <= w_tick && (r_tick_cnt == SampC);
            if (w_tick) begin
                r_tick_cnt <= (r_tick_cnt == TickLast) ? '0 : r_tick_cnt + 1'b1;
                if (r_tick_cnt == SampA || r_tick_cnt == SampB || r_tick_cnt == SampC) begin
                    r_samp <= {r_samp[1:0], r_rxs};
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) w_next = S_START;
            end
            S_START: begin
                if (r_dec && w_maj) w_next = S_IDLE;
                else if (w_bit_end) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && r_bit_cnt == DataLast) begin
                    w_next = (ParityMode != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_last_stop) w_next = w_ferr ? S_WAIT_IDLE : S_IDLE;
            end
            S_WAIT_IDLE: begin
                if (r_rxs) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Frame outcome is resolved at the last stop bit's majority decision, not its end.
    always_comb begin
        w_last_stop = (r_state == S_STOP) && r_dec && (r_bit_cnt == StopLast);
        w_ferr      = r_ferr_acc | ~w_maj;
        w_break     = w_ferr && (r_shift == '0) && ((ParityMode == 0) || !r_par_bit);
        w_busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_par_err    <= 1'b0;
            r_ferr_acc   <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break      <= 1'b0;
        end else begin
            r_rx_valid   <= w_last_stop && !w_break;
            r_parity_err <= w_last_stop && !w_break && r_par_err;
            r_frame_err  <= w_last_stop && !w_break && w_ferr;
            r_break      <= w_last_stop && w_break;
            if (w_last_stop && !w_break) r_rx_data <= r_shift;

            if (w_start_edge) begin
                r_bit_cnt  <= '0;
                r_par_bit  <= 1'b0;
                r_par_err  <= 1'b0;
                r_ferr_acc <= 1'b0;
            end

            case (r_state)
                S_DATA: begin
                    if (r_dec) r_shift <= {w_maj, r_shift[DataBits-1:1]};
                    if (w_bit_end) r_bit_cnt <= (r_bit_cnt == DataLast) ? '0 : r_bit_cnt + 1'b1;
                end
                S_PARITY: begin
                    if (r_dec) begin
                        r_par_bit <= w_maj;
                        r_par_err <= (^r_shift) ^ w_maj ^ logic'(ParityMode == 2);
                    end
                end
                S_STOP: begin
                    if (r_dec && !w_maj) r_ferr_acc <= 1'b1;
                    if (w_bit_end) r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_rx_if.o_rx_valid   = r_rx_valid;
    assign o_rx_if.o_rx_data    = r_rx_data;
    assign o_rx_if.o_parity_err = r_parity_err;
    assign o_rx_if.o_frame_err  = r_frame_err;
    assign o_rx_if.o_break      = r_break;
    assign o_rx_if.o_busy       = w_busy;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7O2 instance, each fed
// a bit-banged serial line with hand-computed expected results.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int BitClk = 224;  // Div 14 * Oversample 16

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    int           va_cnt = 0;
    logic [7:0]   va_data = '0;
    logic         va_perr = 1'b0;
    logic         va_ferr = 1'b0;
    int           brk_a = 0;
    int           vb_cnt = 0;
    logic [6:0]   vb_data = '0;
    logic         vb_perr = 1'b0;
    logic         vb_ferr = 1'b0;
    int           brk_b = 0;

    uart_rx_cfg_if #(.DataBits(8)) ifa ();
    uart_rx_cfg_if #(.DataBits(7)) ifb ();

    uart_rx_cfg #(
        .ClkFreq(27_000_000), .BaudRate(115200), .DataBits(8),
        .ParityMode(0), .StopBits(1), .Oversample(16)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_rx(rx_a), .o_rx_if(ifa)
    );

    uart_rx_cfg #(
        .ClkFreq(27_000_000), .BaudRate(115200), .DataBits(7),
        .ParityMode(2), .StopBits(2), .Oversample(16)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_rx(rx_b), .o_rx_if(ifb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifa.o_rx_valid) begin
            va_cnt++;
            va_data = ifa.o_rx_data;
            va_perr = ifa.o_parity_err;
            va_ferr = ifa.o_frame_err;
        end
        if (ifa.o_break) brk_a++;
        if (ifb.o_rx_valid) begin
            vb_cnt++;
            vb_data = ifb.o_rx_data;
            vb_perr = ifb.o_parity_err;
            vb_ferr = ifb.o_frame_err;
        end
        if (ifb.o_break) brk_b++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(sel, bits[i]);
            repeat (BitClk) @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] bytes_a [4];
        logic [7:0] b;
        int exp_va;

        bytes_a[0] = 8'h00;
        bytes_a[1] = 8'hFF;
        bytes_a[2] = 8'hA5;
        bytes_a[3] = 8'h5A;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(ifa.o_rx_valid), 32'h0);
        check("rst_data", 32'(ifa.o_rx_data), 32'h0);
        check("rst_perr", 32'(ifa.o_parity_err), 32'h0);
        check("rst_ferr", 32'(ifa.o_frame_err), 32'h0);
        check("rst_break", 32'(ifa.o_break), 32'h0);
        check("rst_busy", 32'(ifa.o_busy), 32'h0);
        check("rst_busy_b", 32'(ifb.o_busy), 32'h0);
        repeat (BitClk) @(negedge clk);

        // 8N1 frames: start 0, data LSB first, stop 1
        exp_va = 0;
        for (int k = 0; k < 4; k++) begin
            b = bytes_a[k];
            send_bits(0, 16'({1'b1, b, 1'b0}), 10);
            repeat (20) @(negedge clk);
            exp_va++;
            check("8n1_count", 32'(va_cnt), 32'(exp_va));
            check("8n1_data", 32'(va_data), 32'(b));
            check("8n1_perr", 32'(va_perr), 32'h0);
            check("8n1_ferr", 32'(va_ferr), 32'h0);
            check("8n1_busy", 32'(ifa.o_busy), 32'h0);
        end
        check("8n1_no_break", 32'(brk_a), 32'h0);

        // 7O2, 0x41 has two ones -> odd parity bit = 1
        send_bits(1, 16'({2'b11, 1'b1, 7'h41, 1'b0}), 11);
        repeat (20) @(negedge clk);
        check("7o2_count", 32'(vb_cnt), 32'd1);
        check("7o2_data", 32'(vb_data), 32'h41);
        check("7o2_perr", 32'(vb_perr), 32'h0);
        check("7o2_ferr", 32'(vb_ferr), 32'h0);
        send_bits(1, 16'({2'b11, 1'b0, 7'h41, 1'b0}), 11);
        repeat (20) @(negedge clk);
        check("7o2_bad_count", 32'(vb_cnt), 32'd2);
        check("7o2_bad_data", 32'(vb_data), 32'h41);
        check("7o2_bad_perr", 32'(vb_perr), 32'h1);
        check("7o2_bad_ferr", 32'(vb_ferr), 32'h0);
        check("7o2_busy", 32'(ifb.o_busy), 32'h0);

        // 0x3C with stop bit held low for one bit time
        send_bits(0, 16'({1'b0, 8'h3C, 1'b0}), 10);
        check("ferr_wait_busy", 32'(ifa.o_busy), 32'h1);
        exp_va++;
        check("ferr_count", 32'(va_cnt), 32'(exp_va));
        check("ferr_data", 32'(va_data), 32'h3C);
        check("ferr_flag", 32'(va_ferr), 32'h1);
        check("ferr_perr", 32'(va_perr), 32'h0);
        rx_a = 1'b1;
        repeat (6) @(negedge clk);
        check("ferr_idle_busy", 32'(ifa.o_busy), 32'h0);
        check("ferr_no_break", 32'(brk_a), 32'h0);
        repeat (BitClk) @(negedge clk);

        // Line held low for two frame times
        rx_a = 1'b0;
        repeat (20 * BitClk) @(negedge clk);
        check("brk_count", 32'(brk_a), 32'd1);
        check("brk_no_valid", 32'(va_cnt), 32'(exp_va));
        check("brk_busy_low", 32'(ifa.o_busy), 32'h1);
        rx_a = 1'b1;
        repeat (6) @(negedge clk);
        check("brk_busy_idle", 32'(ifa.o_busy), 32'h0);
        repeat (BitClk) @(negedge clk);

        // 3-clock glitch: false start
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (5) @(negedge clk);
        check("glitch_busy_seen", 32'(ifa.o_busy), 32'h1);
        repeat (BitClk) @(negedge clk);
        check("glitch_busy_clear", 32'(ifa.o_busy), 32'h0);
        check("glitch_no_valid", 32'(va_cnt), 32'(exp_va));
        check("glitch_no_break", 32'(brk_a), 32'd1);

        // Reset during bit 4 of 0x96, then 0x69
        b = 8'h96;
        send_bits(0, 16'({b[3:0], 1'b0}), 5);
        rx_a = b[4];
        repeat (100) @(negedge clk);
        check("midrst_busy_before", 32'(ifa.o_busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_a = 1'b1;
        check("midrst_busy_after", 32'(ifa.o_busy), 32'h0);
        check("midrst_data_clr", 32'(ifa.o_rx_data), 32'h0);
        check("midrst_data_clr_b", 32'(ifb.o_rx_data), 32'h0);
        repeat (3 * BitClk) @(negedge clk);
        check("midrst_no_valid", 32'(va_cnt), 32'(exp_va));
        b = 8'h69;
        send_bits(0, 16'({1'b1, b, 1'b0}), 10);
        repeat (20) @(negedge clk);
        exp_va++;
        check("post_rst_count", 32'(va_cnt), 32'(exp_va));
        check("post_rst_data", 32'(va_data), 32'h69);
        check("post_rst_ferr", 32'(va_ferr), 32'h0);
        check("post_rst_break", 32'(brk_a), 32'd1);
        check("b_no_break", 32'(brk_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
